// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the memory pipeline stage.
//   state_e                      : IDLE / WAIT controller states
//   ALUR, ADD                    : opcode constants used by the pipeline
//   DEFAULT_DBITS                : default data/address width
//   DEFAULT_REG_INDEX_BIT_WIDTH  : default register index width
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [3:0] ALUR = 4'b1100;
  localparam logic [3:0] ADD  = 4'b0111;

  localparam int unsigned DEFAULT_DBITS               = 32;
  localparam int unsigned DEFAULT_REG_INDEX_BIT_WIDTH = 4;

endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: counts cycles spent waiting on memory and flags expiry.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   wait_i     controller is in WAIT this cycle
//   exit_i     controller leaves WAIT at the coming edge
//   expired_o  count has reached TIMEOUT_CYCLES
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic wait_i,
  input  logic exit_i,
  output logic expired_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry forces a WAIT exit, so the count never needs to saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (!wait_i || exit_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage. Issues loads/stores to a ready-handshaked
// memory, stalls upstream while the access is outstanding, and registers the
// write-back fields (ME_*).
// Optional feature macro: MEM_STAGE_TIMEOUT_EN -- abandon an access after
// TIMEOUT_CYCLES wait cycles, insert a bubble and raise sticky mem_err.
// Ports:
//   clk, reset                      clock / synchronous active-high reset
//   EX_*                            EX/ME pipeline register fields
//   mem_req/we/addr/wdata           memory request (outputs)
//   mem_rdata, mem_ready            memory response (inputs)
//   stall                           hold upstream stages
//   ME_result/rd/wrReg/func/op      registered write-back fields
//   mem_err                         sticky timeout flag
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DBITS               = DEFAULT_DBITS,
  parameter int unsigned REG_INDEX_BIT_WIDTH = DEFAULT_REG_INDEX_BIT_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES      = 15
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [3:0]                     EX_func,
  input  logic [3:0]                     EX_op,
  input  logic [DBITS-1:0]               EX_regData2,
  input  logic [DBITS-1:0]               EX_intermediateResult,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] EX_rs2,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] EX_rd,
  input  logic                           EX_ME_mux_sel,
  input  logic                           EX_wrReg,
  input  logic                           EX_wrMem,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [DBITS-1:0]               mem_addr,
  output logic [DBITS-1:0]               mem_wdata,
  input  logic [DBITS-1:0]               mem_rdata,
  input  logic                           mem_ready,
  output logic                           stall,
  output logic [DBITS-1:0]               ME_result,
  output logic [REG_INDEX_BIT_WIDTH-1:0] ME_rd,
  output logic                           ME_wrReg,
  output logic [3:0]                     ME_func,
  output logic [3:0]                     ME_op,
  output logic                           mem_err
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("mem_stage: TIMEOUT_CYCLES must be at least 1");
  end

  state_e state_q, state_d;

  logic                           mem_op;
  logic                           is_load;
  logic                           timeout;
  logic                           bubble;
  logic [DBITS-1:0]               result_d;
  logic [DBITS-1:0]               me_result_q;
  logic [REG_INDEX_BIT_WIDTH-1:0] me_rd_q;
  logic                           me_wrreg_q;
  logic [3:0]                     me_func_q;
  logic [3:0]                     me_op_q;
  logic                           unused_rs2;

  assign unused_rs2 = ^EX_rs2;

  assign mem_op  = EX_wrMem | EX_ME_mux_sel;
  // Store takes priority when both store and load selects are set.
  assign is_load = EX_ME_mux_sel & ~EX_wrMem;

`ifdef MEM_STAGE_TIMEOUT_EN
  logic expired;
  logic mem_err_q;

  mem_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk       (clk),
    .reset     (reset),
    .wait_i    (state_q == WAIT),
    .exit_i    (state_d == IDLE),
    .expired_o (expired)
  );

  // A response arriving on the expiry cycle still completes normally.
  assign timeout = (state_q == WAIT) && mem_op && !mem_ready && expired;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_err_q <= 1'b0;
    end else if (timeout) begin
      mem_err_q <= 1'b1;
    end
  end

  assign mem_err = mem_err_q;
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    stall     = 1'b0;
    bubble    = 1'b0;
    if (mem_op) begin
      if (timeout) begin
        bubble  = 1'b1;
        state_d = IDLE;
      end else begin
        mem_req   = 1'b1;
        mem_we    = EX_wrMem;
        mem_addr  = EX_intermediateResult;
        mem_wdata = EX_regData2;
        stall     = !mem_ready;
        state_d   = mem_ready ? IDLE : WAIT;
      end
    end else begin
      state_d = IDLE;
    end
  end

  assign result_d = is_load ? mem_rdata : EX_intermediateResult;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      me_result_q <= '0;
      me_rd_q     <= '0;
      me_wrreg_q  <= 1'b0;
      me_func_q   <= '0;
      me_op_q     <= '0;
    end else begin
      state_q <= state_d;
      if (!stall) begin
        if (bubble) begin
          me_result_q <= '0;
          me_rd_q     <= '0;
          me_wrreg_q  <= 1'b0;
          me_func_q   <= '0;
          me_op_q     <= '0;
        end else begin
          me_result_q <= result_d;
          me_rd_q     <= EX_rd;
          me_wrreg_q  <= EX_wrReg;
          me_func_q   <= EX_func;
          me_op_q     <= EX_op;
        end
      end
    end
  end

  assign ME_result = me_result_q;
  assign ME_rd     = me_rd_q;
  assign ME_wrReg  = me_wrreg_q;
  assign ME_func   = me_func_q;
  assign ME_op     = me_op_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int unsigned DB = 32;
  localparam int unsigned RW = 4;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    EX_func, EX_op;
  logic [DB-1:0] EX_regData2, EX_intermediateResult;
  logic [RW-1:0] EX_rs2, EX_rd;
  logic          EX_ME_mux_sel, EX_wrReg, EX_wrMem;
  logic          mem_req, mem_we;
  logic [DB-1:0] mem_addr, mem_wdata, mem_rdata;
  logic          mem_ready;
  logic          stall;
  logic [DB-1:0] ME_result;
  logic [RW-1:0] ME_rd;
  logic          ME_wrReg;
  logic [3:0]    ME_func, ME_op;
  logic          mem_err;

  mem_stage #(
    .DBITS               (DB),
    .REG_INDEX_BIT_WIDTH (RW),
    .TIMEOUT_CYCLES      (TO)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .EX_func               (EX_func),
    .EX_op                 (EX_op),
    .EX_regData2           (EX_regData2),
    .EX_intermediateResult (EX_intermediateResult),
    .EX_rs2                (EX_rs2),
    .EX_rd                 (EX_rd),
    .EX_ME_mux_sel         (EX_ME_mux_sel),
    .EX_wrReg              (EX_wrReg),
    .EX_wrMem              (EX_wrMem),
    .mem_req               (mem_req),
    .mem_we                (mem_we),
    .mem_addr              (mem_addr),
    .mem_wdata             (mem_wdata),
    .mem_rdata             (mem_rdata),
    .mem_ready             (mem_ready),
    .stall                 (stall),
    .ME_result             (ME_result),
    .ME_rd                 (ME_rd),
    .ME_wrReg              (ME_wrReg),
    .ME_func               (ME_func),
    .ME_op                 (ME_op),
    .mem_err               (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DB-1:0] result;
    logic [RW-1:0] rd;
    logic          wr;
    logic [3:0]    func;
    logic [3:0]    op;
  } me_t;

  me_t sb_q[$];
  me_t last_exp;
  int  tests = 0;
  int  fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [DB-1:0] r, input logic [RW-1:0] rd, input logic wr,
                      input logic [3:0] f, input logic [3:0] o);
    me_t e;
    e.result = r; e.rd = rd; e.wr = wr; e.func = f; e.op = o;
    sb_q.push_back(e);
  endtask

  task automatic set_ex(input logic [3:0] o, input logic [3:0] f, input logic [DB-1:0] ir,
                        input logic [DB-1:0] rd2, input logic [RW-1:0] rd, input logic wr,
                        input logic mux, input logic wmem);
    EX_op = o; EX_func = f; EX_intermediateResult = ir; EX_regData2 = rd2;
    EX_rd = rd; EX_rs2 = 4'hF; EX_wrReg = wr; EX_ME_mux_sel = mux; EX_wrMem = wmem;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Monitor: ME fields update on every edge that is a reset edge or not stalled;
  // on stalled edges they must stay frozen at the last expected value.
  initial begin
    last_exp = '0;
    forever begin
      logic capt;
      @(posedge clk);
      capt = reset || !stall;
      #1;
      if (capt) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_underflow: got capture with empty queue, expected queued entry");
        end else begin
          last_exp = sb_q.pop_front();
        end
      end
      chk("ME_result", 64'(ME_result), 64'(last_exp.result));
      chk("ME_rd",     64'(ME_rd),     64'(last_exp.rd));
      chk("ME_wrReg",  64'(ME_wrReg),  64'(last_exp.wr));
      chk("ME_func",   64'(ME_func),   64'(last_exp.func));
      chk("ME_op",     64'(ME_op),     64'(last_exp.op));
    end
  end

  initial begin
    reset = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    set_ex(4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    push('0, '0, 1'b0, 4'h0, 4'h0);
    push('0, '0, 1'b0, 4'h0, 4'h0);
    step;
    step;
    reset = 1'b0;
    #1;
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_stall",   64'(stall),   64'd0);
    chk("rst_mem_err", 64'(mem_err), 64'd0);

    // ALU pass-through
    set_ex(ALUR, ADD, 32'd5, 32'd0, 4'd3, 1'b1, 1'b0, 1'b0);
    #1;
    chk("alu_mem_req", 64'(mem_req), 64'd0);
    chk("alu_stall",   64'(stall),   64'd0);
    push(32'd5, 4'd3, 1'b1, ADD, ALUR);
    step;

    // Zero-wait load
    set_ex(4'h2, 4'h0, 32'h10, 32'h99, 4'd7, 1'b1, 1'b1, 1'b0);
    mem_ready = 1'b1;
    mem_rdata = 32'h2A;
    #1;
    chk("ld0_mem_req",   64'(mem_req),   64'd1);
    chk("ld0_mem_we",    64'(mem_we),    64'd0);
    chk("ld0_mem_addr",  64'(mem_addr),  64'h10);
    chk("ld0_mem_wdata", 64'(mem_wdata), 64'h99);
    chk("ld0_stall",     64'(stall),     64'd0);
    push(32'h2A, 4'd7, 1'b1, 4'h0, 4'h2);
    step;

    // 3-wait store, load select also set (store must win)
    set_ex(4'h3, 4'h1, 32'd5, 32'd2, 4'd0, 1'b0, 1'b1, 1'b1);
    mem_ready = 1'b0;
    mem_rdata = 32'hDEAD;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_stall",     64'(stall),     64'd1);
      chk("st_mem_req",   64'(mem_req),   64'd1);
      chk("st_mem_we",    64'(mem_we),    64'd1);
      chk("st_mem_wdata", 64'(mem_wdata), 64'd2);
      chk("st_mem_addr",  64'(mem_addr),  64'd5);
      step;
    end
    mem_ready = 1'b1;
    #1;
    chk("st_done_stall", 64'(stall), 64'd0);
    push(32'd5, 4'd0, 1'b0, 4'h1, 4'h3);
    step;

    // mem_ready with no request: ignored, memory outputs gated to zero
    set_ex(ALUR, ADD, 32'h1234, 32'h55, 4'd2, 1'b1, 1'b0, 1'b0);
    mem_ready = 1'b1;
    mem_rdata = 32'h77;
    #1;
    chk("idle_mem_req",   64'(mem_req),   64'd0);
    chk("idle_mem_we",    64'(mem_we),    64'd0);
    chk("idle_mem_addr",  64'(mem_addr),  64'd0);
    chk("idle_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("idle_stall",     64'(stall),     64'd0);
    push(32'h1234, 4'd2, 1'b1, ADD, ALUR);
    step;

    // Reset while waiting on a load; reset beats mem_ready
    set_ex(4'h2, 4'h0, 32'h20, 32'h0, 4'd4, 1'b1, 1'b1, 1'b0);
    mem_ready = 1'b0;
    #1;
    chk("rw_stall_idle", 64'(stall), 64'd1);
    step;
    #1;
    chk("rw_stall_wait", 64'(stall), 64'd1);
    step;
    reset = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'h66;
    push('0, '0, 1'b0, 4'h0, 4'h0);
    step;
    reset = 1'b0;
    mem_ready = 1'b0;
    set_ex(ALUR, ADD, 32'h9, 32'h0, 4'd1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("rw_mem_req", 64'(mem_req), 64'd0);
    chk("rw_stall",   64'(stall),   64'd0);
    push(32'h9, 4'd1, 1'b1, ADD, ALUR);
    step;

`ifdef MEM_STAGE_TIMEOUT_EN
    // Response on the expiry cycle completes normally
    set_ex(4'h2, 4'h0, 32'h30, 32'h0, 4'd5, 1'b1, 1'b1, 1'b0);
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("to_edge_stall", 64'(stall), 64'd1);
      step;
    end
    mem_ready = 1'b1;
    mem_rdata = 32'hBEEF;
    #1;
    chk("to_edge_stall_rel", 64'(stall),   64'd0);
    chk("to_edge_mem_req",   64'(mem_req), 64'd1);
    push(32'hBEEF, 4'd5, 1'b1, 4'h0, 4'h2);
    step;
    #1;
    chk("to_edge_mem_err", 64'(mem_err), 64'd0);

    // Real timeout: bubble and sticky error
    set_ex(4'h2, 4'h0, 32'h40, 32'h0, 4'd9, 1'b1, 1'b1, 1'b0);
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("to_stall", 64'(stall), 64'd1);
      step;
    end
    #1;
    chk("to_stall_drop", 64'(stall),    64'd0);
    chk("to_mem_req",    64'(mem_req),  64'd0);
    chk("to_mem_addr",   64'(mem_addr), 64'd0);
    push('0, '0, 1'b0, 4'h0, 4'h0);
    step;
    #1;
    chk("to_mem_err", 64'(mem_err), 64'd1);
    set_ex(ALUR, ADD, 32'h3, 32'h0, 4'd6, 1'b1, 1'b0, 1'b0);
    push(32'h3, 4'd6, 1'b1, ADD, ALUR);
    step;
    #1;
    chk("to_mem_err_sticky", 64'(mem_err), 64'd1);
    reset = 1'b1;
    push('0, '0, 1'b0, 4'h0, 4'h0);
    step;
    reset = 1'b0;
    #1;
    chk("to_mem_err_clr", 64'(mem_err), 64'd0);
`else
    // Without the timeout feature the stage waits indefinitely
    set_ex(4'h2, 4'h0, 32'h40, 32'h0, 4'd9, 1'b1, 1'b1, 1'b0);
    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("nto_stall",   64'(stall),   64'd1);
      chk("nto_mem_req", 64'(mem_req), 64'd1);
      chk("nto_mem_err", 64'(mem_err), 64'd0);
      step;
    end
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE;
    #1;
    chk("nto_stall_rel", 64'(stall), 64'd0);
    push(32'hCAFE, 4'd9, 1'b1, 4'h0, 4'h2);
    step;
    #1;
    chk("nto_mem_err_end", 64'(mem_err), 64'd0);
`endif

    #2;
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
